hc595_receiver: RTL and testbench



---
 rtl/hc595_receiver_if.sv | 25 ++
 rtl/hc595_receiver.sv | 88 ++++++++
 tb/tb_hc595_receiver.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hc595_receiver_if.sv
// rtl/hc595_receiver_if.sv - 74HC595 receive-side pin and result bundle
interface hc595_receiver_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  sh_cp;
    logic                  st_cp;
    logic                  ds;
    logic                  en;
    logic [DATA_WIDTH-1:0] data;
    logic                  data_valid;
    logic [4:0]            bit_cnt;
    logic                  frame_err;

    // Driver side: owns the serial pins and the enable, observes results
    modport master (
        output sh_cp, st_cp, ds, en,
        input  data, data_valid, bit_cnt, frame_err
    );

    // Receiver side
    modport slave (
        input  sh_cp, st_cp, ds, en,
        output data, data_valid, bit_cnt, frame_err
    );
endinterface

// File: rtl/hc595_receiver.sv
// rtl/hc595_receiver.sv - oversampling 74HC595 shift/storage register receiver
module hc595_receiver #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    hc595_receiver_if.slave    bus
);
    localparam logic [4:0] C_FRAME_BITS = 5'(DATA_WIDTH);
    localparam logic [4:0] C_CNT_MAX    = 5'd31;

    logic [SYNC_STAGES-1:0] r_sh_sync;
    logic [SYNC_STAGES-1:0] r_st_sync;
    logic [SYNC_STAGES-1:0] r_ds_sync;
    logic                   r_sh_hist;
    logic                   r_st_hist;
    logic                   r_sh_rise;
    logic                   r_st_rise;
    logic                   r_ds_q;
    logic [DATA_WIDTH-1:0]  r_shreg;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_valid;
    logic [4:0]             r_bit_cnt;
    logic                   r_frame_err;
    logic                   w_sh_rise;
    logic                   w_st_rise;

    assign w_sh_rise = r_sh_sync[SYNC_STAGES-1] & ~r_sh_hist;
    assign w_st_rise = r_st_sync[SYNC_STAGES-1] & ~r_st_hist;

    // Synchronize all three pins with equal depth so ds stays aligned to sh_cp,
    // then register the rise pulses (and the matching ds sample) once more
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sh_sync <= '0;
            r_st_sync <= '0;
            r_ds_sync <= '0;
            r_sh_hist <= 1'b0;
            r_st_hist <= 1'b0;
            r_sh_rise <= 1'b0;
            r_st_rise <= 1'b0;
            r_ds_q    <= 1'b0;
        end else begin
            r_sh_sync <= {r_sh_sync[SYNC_STAGES-2:0], bus.sh_cp};
            r_st_sync <= {r_st_sync[SYNC_STAGES-2:0], bus.st_cp};
            r_ds_sync <= {r_ds_sync[SYNC_STAGES-2:0], bus.ds};
            r_sh_hist <= r_sh_sync[SYNC_STAGES-1];
            r_st_hist <= r_st_sync[SYNC_STAGES-1];
            r_sh_rise <= w_sh_rise;
            r_st_rise <= w_st_rise;
            r_ds_q    <= r_ds_sync[SYNC_STAGES-1];
        end
    end

    // Shift/storage behaviour; a coincident latch sees the pre-shift register
    // and the pre-increment count, and the shifted bit starts the next frame
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shreg     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_bit_cnt   <= 5'd0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (bus.en) begin
                if (r_sh_rise) begin
                    r_shreg <= {r_shreg[DATA_WIDTH-2:0], r_ds_q};
                    if (!r_st_rise && r_bit_cnt != C_CNT_MAX) begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end
                if (r_st_rise) begin
                    r_data      <= r_shreg;
                    r_valid     <= 1'b1;
                    r_frame_err <= (r_bit_cnt != C_FRAME_BITS);
                    r_bit_cnt   <= r_sh_rise ? 5'd1 : 5'd0;
                end
            end
        end
    end

    assign bus.data       = r_data;
    assign bus.data_valid = r_valid;
    assign bus.bit_cnt    = r_bit_cnt;
    assign bus.frame_err  = r_frame_err;
endmodule

// File: tb/tb_hc595_receiver.sv
// tb/tb_hc595_receiver.sv - directed self-checking bench for hc595_receiver
module tb_hc595_receiver;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;
    int   n_valid;

    hc595_receiver_if #(.DATA_WIDTH(16)) bus ();

    hc595_receiver #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Count data_valid cycles, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) n_valid++;
    end

    task automatic pulse_sh(input logic b);
        @(negedge clk);
        bus.ds = b;
        repeat (4) @(negedge clk);
        bus.sh_cp = 1'b1;
        repeat (8) @(negedge clk);
        bus.sh_cp = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) pulse_sh(w[i]);
    endtask

    // Raise st_cp, wait (bounded) for data_valid, return latency and pulse count
    task automatic do_latch(output int lat, output int pulses);
        int v0;
        v0  = n_valid;
        lat = 0;
        @(negedge clk);
        bus.st_cp = 1'b1;
        while (bus.data_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        repeat (8) @(negedge clk);
        bus.st_cp = 1'b0;
        repeat (8) @(negedge clk);
        pulses = n_valid - v0;
    endtask

    task automatic test_reset();
        bus.sh_cp = 0; bus.st_cp = 0; bus.ds = 0; bus.en = 1;
        reset_n = 0;
        repeat (4) @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        n_cmp++;
        if (bus.data !== 16'h0 || bus.data_valid !== 1'b0 ||
            bus.bit_cnt !== 5'd0 || bus.frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset: data=%h valid=%b cnt=%0d err=%b required 0/0/0/0",
                     bus.data, bus.data_valid, bus.bit_cnt, bus.frame_err);
        end
    endtask

    task automatic test_basic_frame();
        int lat, p;
        send_bits(32'hC0FE, 16);
        n_cmp++;
        if (bus.bit_cnt !== 5'd16) begin
            n_err++; $display("FAIL basic_cnt: got %0d required 16", bus.bit_cnt);
        end
        do_latch(lat, p);
        n_cmp++;
        if (lat !== 4) begin
            n_err++; $display("FAIL latency: got %0d required 4", lat);
        end
        n_cmp++;
        if (p !== 1) begin
            n_err++; $display("FAIL valid_width: got %0d required 1", p);
        end
        n_cmp++;
        if (bus.data !== 16'hC0FE || bus.frame_err !== 1'b0 || bus.bit_cnt !== 5'd0) begin
            n_err++;
            $display("FAIL basic: data=%h err=%b cnt=%0d required c0fe/0/0",
                     bus.data, bus.frame_err, bus.bit_cnt);
        end
    endtask

    task automatic test_short_frame();
        int lat, p;
        send_bits(32'hABC, 12);
        do_latch(lat, p);
        n_cmp++;
        if (bus.data !== 16'hEABC || bus.frame_err !== 1'b1) begin
            n_err++;
            $display("FAIL short: data=%h err=%b required eabc/1", bus.data, bus.frame_err);
        end
        send_bits(32'h1357, 16);
        do_latch(lat, p);
        n_cmp++;
        if (bus.data !== 16'h1357 || bus.frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL short_recover: data=%h err=%b required 1357/0", bus.data, bus.frame_err);
        end
    endtask

    task automatic test_long_frame();
        int lat, p;
        send_bits(32'hF1234, 20);
        n_cmp++;
        if (bus.bit_cnt !== 5'd20) begin
            n_err++; $display("FAIL long_cnt: got %0d required 20", bus.bit_cnt);
        end
        do_latch(lat, p);
        n_cmp++;
        if (bus.data !== 16'h1234 || bus.frame_err !== 1'b1) begin
            n_err++;
            $display("FAIL long: data=%h err=%b required 1234/1", bus.data, bus.frame_err);
        end
    endtask

    task automatic test_coincident();
        int lat, p;
        send_bits(32'h5A5A, 16);
        @(negedge clk);
        bus.ds = 1'b1;
        repeat (4) @(negedge clk);
        bus.sh_cp = 1'b1;
        bus.st_cp = 1'b1;
        lat = 0;
        while (bus.data_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        repeat (8) @(negedge clk);
        bus.sh_cp = 1'b0;
        bus.st_cp = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (bus.data !== 16'h5A5A || bus.frame_err !== 1'b0 || bus.bit_cnt !== 5'd1) begin
            n_err++;
            $display("FAIL coincident: data=%h err=%b cnt=%0d required 5a5a/0/1",
                     bus.data, bus.frame_err, bus.bit_cnt);
        end
        // Close the one-bit frame: shift register is 5a5a<<1|1
        do_latch(lat, p);
        n_cmp++;
        if (bus.data !== 16'hB4B5 || bus.frame_err !== 1'b1) begin
            n_err++;
            $display("FAIL coincident_tail: data=%h err=%b required b4b5/1", bus.data, bus.frame_err);
        end
    endtask

    task automatic test_enable();
        int lat, p;
        for (int i = 0; i < 16; i++) begin
            bus.en = (i >= 4 && i < 8) ? 1'b0 : 1'b1;
            pulse_sh(1'b1);
        end
        bus.en = 1'b1;
        n_cmp++;
        if (bus.bit_cnt !== 5'd12) begin
            n_err++; $display("FAIL en_cnt: got %0d required 12", bus.bit_cnt);
        end
        do_latch(lat, p);
        n_cmp++;
        if (bus.data !== 16'h5FFF || bus.frame_err !== 1'b1) begin
            n_err++;
            $display("FAIL en_frame: data=%h err=%b required 5fff/1", bus.data, bus.frame_err);
        end
        // A latch edge while disabled must not update or be replayed later
        bus.en = 1'b0;
        do_latch(lat, p);
        bus.en = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (p !== 0 || bus.data !== 16'h5FFF) begin
            n_err++;
            $display("FAIL en_latch_ignored: pulses=%0d data=%h required 0/5fff", p, bus.data);
        end
        send_bits(32'h8421, 16);
        do_latch(lat, p);
        n_cmp++;
        if (bus.data !== 16'h8421 || bus.frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL en_recover: data=%h err=%b required 8421/0", bus.data, bus.frame_err);
        end
    endtask

    task automatic test_saturation();
        int lat, p;
        send_bits(32'hFFFF_FFFF, 32);
        send_bits(32'h5, 3);
        n_cmp++;
        if (bus.bit_cnt !== 5'd31) begin
            n_err++; $display("FAIL saturate: got %0d required 31", bus.bit_cnt);
        end
        do_latch(lat, p);
        n_cmp++;
        if (bus.data !== 16'hFFFD || bus.frame_err !== 1'b1) begin
            n_err++;
            $display("FAIL saturate_frame: data=%h err=%b required fffd/1", bus.data, bus.frame_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        int lat, p;
        send_bits(32'hA5, 8);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n_cmp++;
        if (bus.data !== 16'h0 || bus.bit_cnt !== 5'd0 || bus.frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: data=%h cnt=%0d err=%b required 0/0/0",
                     bus.data, bus.bit_cnt, bus.frame_err);
        end
        send_bits(32'h0F0F, 16);
        do_latch(lat, p);
        n_cmp++;
        if (bus.data !== 16'h0F0F || bus.frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_frame: data=%h err=%b required 0f0f/0", bus.data, bus.frame_err);
        end
    endtask

    task automatic test_loopback();
        logic [6:0]  seg_tab [4];
        logic [7:0]  sel_tab [4];
        logic [15:0] w;
        int lat, p;
        seg_tab[0] = 7'h3F; sel_tab[0] = 8'h01;
        seg_tab[1] = 7'h06; sel_tab[1] = 8'h80;
        seg_tab[2] = 7'h5B; sel_tab[2] = 8'h24;
        seg_tab[3] = 7'h00; sel_tab[3] = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            w = {1'b1, seg_tab[k], sel_tab[k]};
            send_bits({16'h0, w}, 16);
            do_latch(lat, p);
            n_cmp++;
            if (bus.data !== w || bus.frame_err !== 1'b0 || p !== 1) begin
                n_err++;
                $display("FAIL loopback%0d: data=%h err=%b pulses=%0d required %h/0/1",
                         k, bus.data, bus.frame_err, p, w);
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        n_valid = 0;
        test_reset();
        test_basic_frame();
        test_short_frame();
        test_long_frame();
        test_coincident();
        test_enable();
        test_saturation();
        test_reset_mid_frame();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
